// File: rtl/rom_download_router_pkg.sv
// Shared types and constants for the ROM download router: FSM states, ROM region
// map and default geometry of the download image.
package rom_dl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    ERROR,
    RUN
  } dl_state_e;

  typedef enum logic [1:0] {
    REG_CPU,
    REG_SND,
    REG_GFX,
    REG_PROM
  } region_e;

  localparam int NUM_REGIONS = 4;

  // Region bases must stay in ascending order; the decoder picks the highest base <= addr.
  localparam logic [NUM_REGIONS-1:0][15:0] REGION_BASE = {
    16'hF000, 16'h6000, 16'h4000, 16'h0000
  };

  localparam logic [31:0] DEF_TOTAL_BYTES  = 32'h0001_0000;
  localparam logic [31:0] DEF_EXPECT_BYTES = 32'h0001_0000;
  localparam int unsigned DEF_HOLD_CYCLES  = 16;

  localparam logic [16:0] BYTES_SAT = 17'h1FFFF;

  function automatic logic [16:0] sat_inc(input logic [16:0] v);
    return (v == BYTES_SAT) ? v : v + 17'd1;
  endfunction

endpackage

// File: rtl/rom_download_router_if.sv
// hps_io ioctl download bus as seen by the ROM router; hps_io is the master,
// the router the slave.
interface rom_download_router_if;

  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (
    output ioctl_download,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout
  );

  modport slave (
    input ioctl_download,
    input ioctl_wr,
    input ioctl_addr,
    input ioctl_dout
  );

endinterface

// File: rtl/rom_region_decode.sv
// Combinational ROM region lookup: returns the index of the highest region base
// that does not exceed the address.
module rom_region_decode
  import rom_dl_pkg::*;
(
  input  logic [15:0] addr,
  output region_e     region
);

  always_comb begin
    region = REG_CPU;
    for (int i = 1; i < NUM_REGIONS; i++) begin
      if (addr >= REGION_BASE[i]) begin
        region = region_e'(2'(i));
      end
    end
  end

endmodule

// File: rtl/rom_download_router.sv
// Registers the hps_io ROM byte stream onto the core dn_* port, validates the
// download and sequences core reset. Optional running checksum: define ROM_CKSUM_EN.
module rom_download_router
  import rom_dl_pkg::*;
#(
  parameter logic [31:0] TOTAL_BYTES  = DEF_TOTAL_BYTES,
  parameter logic [31:0] EXPECT_BYTES = DEF_EXPECT_BYTES,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter bit          STRICT       = 1'b1
`ifdef ROM_CKSUM_EN
  ,
  parameter logic [15:0] CKSUM_EXPECT = 16'h0000
`endif
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  rom_download_router_if.slave  ioctl,
  output logic [15:0]           dn_addr,
  output logic [7:0]            dn_data,
  output logic                  dn_wr,
  output logic [1:0]            dn_region,
  output logic                  core_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [16:0]           bytes_loaded
`ifdef ROM_CKSUM_EN
  ,
  output logic [15:0]           cksum
`endif
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  dl_state_e   state_q, state_d;
  logic        dl_q, dl_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [15:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic        dn_wr_q, dn_wr_d;
  logic [1:0]  dn_region_q, dn_region_d;
  logic        core_reset_q, core_reset_d;
  logic        load_done_q, load_done_d;
  logic        load_error_q, load_error_d;
  logic [16:0] bytes_loaded_q, bytes_loaded_d;

  region_e     addr_region;
  logic        dl_fall;
  logic        in_range;
  logic        accept;
  logic        overrun;
  logic [16:0] count_next;
  logic        cksum_bad;
  logic        end_err;

  rom_region_decode u_region_decode (
    .addr   (ioctl.ioctl_addr[15:0]),
    .region (addr_region)
  );

  assign dl_fall    = dl_q & ~ioctl.ioctl_download;
  assign in_range   = ({7'd0, ioctl.ioctl_addr} < TOTAL_BYTES);
  assign accept     = (state_q == LOAD) & ioctl.ioctl_wr & in_range;
  assign overrun    = (state_q == LOAD) & ioctl.ioctl_wr & ~in_range;
  assign count_next = accept ? sat_inc(bytes_loaded_q) : bytes_loaded_q;

`ifdef ROM_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;
  logic [15:0] cksum_next;

  // The byte landing on the download-end cycle is already folded into cksum_next.
  assign cksum_next = accept ? cksum_q + {8'd0, ioctl.ioctl_dout} : cksum_q;
  assign cksum_bad  = (CKSUM_EXPECT != 16'h0000) && (cksum_next != CKSUM_EXPECT);
  assign cksum      = cksum_q;
`else
  assign cksum_bad  = 1'b0;
`endif

  assign end_err = load_error_q | overrun | ({15'd0, count_next} != EXPECT_BYTES) | cksum_bad;

  always_comb begin
    state_d        = state_q;
    dl_d           = ioctl.ioctl_download;
    hold_cnt_d     = hold_cnt_q;
    dn_wr_d        = 1'b0;
    dn_addr_d      = dn_addr_q;
    dn_data_d      = dn_data_q;
    dn_region_d    = dn_region_q;
    bytes_loaded_d = bytes_loaded_q;
    load_error_d   = load_error_q;
`ifdef ROM_CKSUM_EN
    cksum_d        = cksum_q;
`endif

    if (accept) begin
      dn_wr_d     = 1'b1;
      dn_addr_d   = ioctl.ioctl_addr[15:0];
      dn_data_d   = ioctl.ioctl_dout;
      dn_region_d = addr_region;
    end

    case (state_q)
      LOAD: begin
        bytes_loaded_d = count_next;
        load_error_d   = load_error_q | overrun;
`ifdef ROM_CKSUM_EN
        cksum_d        = cksum_next;
`endif
        if (dl_fall) begin
          load_error_d = end_err;
          hold_cnt_d   = '0;
          state_d      = (end_err && STRICT) ? ERROR : HOLD;
        end
      end
      HOLD: begin
        if (ioctl.ioctl_download) begin
          state_d = LOAD;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      IDLE, ERROR, RUN: begin
        if (ioctl.ioctl_download) begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh download always starts from a clean count and error flag.
    if (state_q != LOAD && state_d == LOAD) begin
      bytes_loaded_d = '0;
      load_error_d   = 1'b0;
`ifdef ROM_CKSUM_EN
      cksum_d        = '0;
`endif
    end

    core_reset_d = (state_d != RUN);
    load_done_d  = (state_d == RUN);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      dl_q           <= 1'b0;
      hold_cnt_q     <= '0;
      dn_addr_q      <= '0;
      dn_data_q      <= '0;
      dn_wr_q        <= 1'b0;
      dn_region_q    <= '0;
      core_reset_q   <= 1'b1;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
      bytes_loaded_q <= '0;
`ifdef ROM_CKSUM_EN
      cksum_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      dl_q           <= dl_d;
      hold_cnt_q     <= hold_cnt_d;
      dn_addr_q      <= dn_addr_d;
      dn_data_q      <= dn_data_d;
      dn_wr_q        <= dn_wr_d;
      dn_region_q    <= dn_region_d;
      core_reset_q   <= core_reset_d;
      load_done_q    <= load_done_d;
      load_error_q   <= load_error_d;
      bytes_loaded_q <= bytes_loaded_d;
`ifdef ROM_CKSUM_EN
      cksum_q        <= cksum_d;
`endif
    end
  end

  assign dn_addr      = dn_addr_q;
  assign dn_data      = dn_data_q;
  assign dn_wr        = dn_wr_q;
  assign dn_region    = dn_region_q;
  assign core_reset   = core_reset_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;
  assign bytes_loaded = bytes_loaded_q;

endmodule

// File: tb/tb_rom_download_router.sv
// Randomized self-checking bench for rom_download_router: a strict and a lenient
// instance share one ioctl bus and are checked against a transaction-level model.
module tb_rom_download_router;

  localparam int EXP  = 48;
  localparam int HOLD = 16;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk_sys = ~clk_sys;

  rom_download_router_if ioctl_bus ();

  logic [15:0] dn_addr      [2];
  logic [7:0]  dn_data      [2];
  logic        dn_wr        [2];
  logic [1:0]  dn_region    [2];
  logic        core_reset   [2];
  logic        load_done    [2];
  logic        load_error   [2];
  logic [16:0] bytes_loaded [2];
`ifdef ROM_CKSUM_EN
  logic [15:0] cksum        [2];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [24:0] q_addr [$];
  logic [7:0]  q_data [$];
  logic [15:0] exp_addr   = '0;
  logic [7:0]  exp_data   = '0;
  logic [1:0]  exp_region = '0;
  logic [15:0] exp_sum    = '0;

  rom_download_router #(
    .EXPECT_BYTES (32'(EXP)),
    .HOLD_CYCLES  (HOLD),
    .STRICT       (1'b1)
  ) u_strict (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl        (ioctl_bus),
    .dn_addr      (dn_addr[0]),
    .dn_data      (dn_data[0]),
    .dn_wr        (dn_wr[0]),
    .dn_region    (dn_region[0]),
    .core_reset   (core_reset[0]),
    .load_done    (load_done[0]),
    .load_error   (load_error[0]),
    .bytes_loaded (bytes_loaded[0])
`ifdef ROM_CKSUM_EN
    ,
    .cksum        (cksum[0])
`endif
  );

  rom_download_router #(
    .EXPECT_BYTES (32'(EXP)),
    .HOLD_CYCLES  (HOLD),
    .STRICT       (1'b0)
  ) u_lax (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl        (ioctl_bus),
    .dn_addr      (dn_addr[1]),
    .dn_data      (dn_data[1]),
    .dn_wr        (dn_wr[1]),
    .dn_region    (dn_region[1]),
    .core_reset   (core_reset[1]),
    .load_done    (load_done[1]),
    .load_error   (load_error[1]),
    .bytes_loaded (bytes_loaded[1])
`ifdef ROM_CKSUM_EN
    ,
    .cksum        (cksum[1])
`endif
  );

  // Reference region map written straight from the ROM memory layout.
  function automatic logic [1:0] ref_region(input logic [15:0] a);
    if (a >= 16'hF000) return 2'd3;
    if (a >= 16'h6000) return 2'd2;
    if (a >= 16'h4000) return 2'd1;
    return 2'd0;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic fill_random(input int n);
    q_addr.delete();
    q_data.delete();
    for (int k = 0; k < n; k++) begin
      q_addr.push_back(25'($urandom_range(32'hFFFF)));
      q_data.push_back(8'($urandom_range(255)));
    end
  endtask

  // Plays q_addr/q_data as one download and checks the dn path, the count,
  // the end-of-download verdict and the reset release timing of both instances.
  task automatic run_download(input string name, input bit last_on_fall);
    int          cnt;
    bit          ovr;
    bit          fin_err;
    bit          fall_now;
    bit          acc;
    int          first_rel [2];
    int          want_rel;
    logic [24:0] a;
    cnt     = 0;
    ovr     = 1'b0;
    exp_sum = '0;

    ioctl_bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (core_reset[i] !== 1'b1 || bytes_loaded[i] !== 17'd0 || load_error[i] !== 1'b0)
        $display("FAIL %s load_entry inst%0d: got core_reset=%0b bytes=%0d err=%0b expected 1/0/0",
                 name, i, core_reset[i], bytes_loaded[i], load_error[i]);
      else n_pass++;
    end

    for (int j = 0; j < q_addr.size(); j++) begin
      a        = q_addr[j];
      fall_now = last_on_fall && (j == q_addr.size() - 1);
      acc      = (a < 25'h10000);
      ioctl_bus.ioctl_wr   = 1'b1;
      ioctl_bus.ioctl_addr = a;
      ioctl_bus.ioctl_dout = q_data[j];
      if (fall_now) ioctl_bus.ioctl_download = 1'b0;
      tick();
      ioctl_bus.ioctl_wr = 1'b0;
      if (acc) begin
        cnt++;
        exp_addr   = a[15:0];
        exp_data   = q_data[j];
        exp_region = ref_region(a[15:0]);
        exp_sum    = exp_sum + {8'd0, q_data[j]};
      end else begin
        ovr = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (dn_wr[i] !== acc)
          $display("FAIL %s dn_wr inst%0d byte%0d: got %0b expected %0b", name, i, j, dn_wr[i], acc);
        else n_pass++;
        n_checks++;
        if (dn_addr[i] !== exp_addr || dn_data[i] !== exp_data || dn_region[i] !== exp_region)
          $display("FAIL %s dn_bus inst%0d byte%0d: got %h/%h/%0d expected %h/%h/%0d", name, i, j,
                   dn_addr[i], dn_data[i], dn_region[i], exp_addr, exp_data, exp_region);
        else n_pass++;
        if (!fall_now) begin
          n_checks++;
          if (bytes_loaded[i] !== 17'(cnt) || load_error[i] !== ovr)
            $display("FAIL %s progress inst%0d byte%0d: got bytes=%0d err=%0b expected %0d/%0b",
                     name, i, j, bytes_loaded[i], load_error[i], cnt, ovr);
          else n_pass++;
        end
      end
      if (!fall_now && $urandom_range(3) == 0) begin
        tick();
        for (int i = 0; i < 2; i++) begin
          n_checks++;
          if (dn_wr[i] !== 1'b0 || dn_addr[i] !== exp_addr || dn_data[i] !== exp_data)
            $display("FAIL %s idle_hold inst%0d: got wr=%0b %h/%h expected 0 %h/%h",
                     name, i, dn_wr[i], dn_addr[i], dn_data[i], exp_addr, exp_data);
          else n_pass++;
        end
      end
    end

    if (!last_on_fall) begin
      ioctl_bus.ioctl_download = 1'b0;
      tick();
    end
    fin_err = ovr || (cnt != EXP);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (load_error[i] !== fin_err || bytes_loaded[i] !== 17'(cnt) || core_reset[i] !== 1'b1)
        $display("FAIL %s end_check inst%0d: got err=%0b bytes=%0d core_reset=%0b expected %0b/%0d/1",
                 name, i, load_error[i], bytes_loaded[i], core_reset[i], fin_err, cnt);
      else n_pass++;
      first_rel[i] = -1;
    end

    for (int k = 1; k <= HOLD + 3; k++) begin
      tick();
      for (int i = 0; i < 2; i++)
        if (first_rel[i] < 0 && core_reset[i] === 1'b0) first_rel[i] = k;
    end
    for (int i = 0; i < 2; i++) begin
      want_rel = (fin_err && i == 0) ? -1 : HOLD;
      n_checks++;
      if (first_rel[i] != want_rel)
        $display("FAIL %s release inst%0d: got release cycle %0d expected %0d", name, i, first_rel[i], want_rel);
      else n_pass++;
      n_checks++;
      if (load_done[i] !== (want_rel > 0) || load_error[i] !== fin_err)
        $display("FAIL %s final inst%0d: got done=%0b err=%0b expected %0b/%0b",
                 name, i, load_done[i], load_error[i], (want_rel > 0), fin_err);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    ioctl_bus.ioctl_download = 1'b0;
    ioctl_bus.ioctl_wr       = 1'b0;
    ioctl_bus.ioctl_addr     = '0;
    ioctl_bus.ioctl_dout     = '0;
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({dn_addr[i], dn_data[i], dn_wr[i], dn_region[i], core_reset[i], load_done[i], load_error[i], bytes_loaded[i]}
          !== {16'h0, 8'h0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 17'd0})
        $display("FAIL reset_values inst%0d: got %h/%h/%0b/%0d/%0b/%0b/%0b/%0d expected 0/0/0/0/1/0/0/0", i,
                 dn_addr[i], dn_data[i], dn_wr[i], dn_region[i], core_reset[i], load_done[i], load_error[i], bytes_loaded[i]);
      else n_pass++;
    end
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (core_reset[i] !== 1'b1 || load_done[i] !== 1'b0)
        $display("FAIL idle_after_reset inst%0d: got core_reset=%0b done=%0b expected 1/0", i, core_reset[i], load_done[i]);
      else n_pass++;
    end
  endtask

  task automatic test_full_load();
    fill_random(EXP);
    run_download("full_load", 1'b0);
  endtask

  task automatic test_overrun();
    int pos;
    fill_random(EXP);
    pos = int'($urandom_range(EXP - 1));
    q_addr.insert(pos, 25'h10000);
    q_data.insert(pos, 8'hA5);
    run_download("overrun", 1'b0);
  endtask

  task automatic test_short_load();
    fill_random(EXP - 1);
    run_download("short_load", 1'b0);
  endtask

  task automatic test_last_on_fall();
    fill_random(EXP);
    run_download("last_on_fall", 1'b1);
  endtask

  task automatic test_ignored_wr();
    for (int k = 0; k < 4; k++) begin
      ioctl_bus.ioctl_wr   = 1'b1;
      ioctl_bus.ioctl_addr = 25'($urandom_range(32'hFFFF));
      ioctl_bus.ioctl_dout = 8'($urandom_range(255));
      tick();
      ioctl_bus.ioctl_wr = 1'b0;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (dn_wr[i] !== 1'b0 || dn_addr[i] !== exp_addr || bytes_loaded[i] !== 17'(EXP) || core_reset[i] !== 1'b0)
          $display("FAIL ignored_wr inst%0d: got wr=%0b addr=%h bytes=%0d core_reset=%0b expected 0/%h/%0d/0",
                   i, dn_wr[i], dn_addr[i], bytes_loaded[i], core_reset[i], exp_addr, EXP);
        else n_pass++;
      end
    end
  endtask

  task automatic test_region_edges();
    logic [15:0] edges [8];
    edges = '{16'h3FFF, 16'h4000, 16'h5FFF, 16'h6000, 16'hEFFF, 16'hF000, 16'hFFFF, 16'h0000};
    fill_random(EXP - 8);
    for (int k = 0; k < 8; k++) begin
      q_addr.push_front(25'(edges[k]));
      q_data.push_front(8'($urandom_range(255)));
    end
    run_download("region_edges", 1'b0);
  endtask

  task automatic test_reset_mid_load();
    ioctl_bus.ioctl_download = 1'b1;
    tick();
    for (int a = 16'h1FF0; a <= 16'h2000; a++) begin
      ioctl_bus.ioctl_wr   = 1'b1;
      ioctl_bus.ioctl_addr = 25'(a);
      ioctl_bus.ioctl_dout = 8'($urandom_range(255));
      tick();
    end
    ioctl_bus.ioctl_wr = 1'b0;
    n_checks++;
    if (dn_wr[0] !== 1'b1 || dn_addr[0] !== 16'h2000 || bytes_loaded[0] !== 17'd17)
      $display("FAIL mid_load_progress: got wr=%0b addr=%h bytes=%0d expected 1/2000/17", dn_wr[0], dn_addr[0], bytes_loaded[0]);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({dn_addr[i], dn_data[i], dn_wr[i], dn_region[i], core_reset[i], load_done[i], load_error[i], bytes_loaded[i]}
          !== {16'h0, 8'h0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 17'd0})
        $display("FAIL mid_load_reset inst%0d: got %h/%h/%0b/%0d/%0b/%0b/%0b/%0d expected 0/0/0/0/1/0/0/0", i,
                 dn_addr[i], dn_data[i], dn_wr[i], dn_region[i], core_reset[i], load_done[i], load_error[i], bytes_loaded[i]);
      else n_pass++;
    end
    ioctl_bus.ioctl_download = 1'b0;
    exp_addr   = '0;
    exp_data   = '0;
    exp_region = '0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < HOLD + 4; k++) tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (core_reset[i] !== 1'b1 || load_done[i] !== 1'b0 || bytes_loaded[i] !== 17'd0)
        $display("FAIL no_partial_release inst%0d: got core_reset=%0b done=%0b bytes=%0d expected 1/0/0",
                 i, core_reset[i], load_done[i], bytes_loaded[i]);
      else n_pass++;
    end
  endtask

`ifdef ROM_CKSUM_EN
  task automatic test_cksum();
    fill_random(EXP);
    for (int k = 3; k < EXP; k++) q_data[k] = 8'h00;
    q_data[0] = 8'h01;
    q_data[1] = 8'h02;
    q_data[2] = 8'hFF;
    run_download("cksum", 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (cksum[i] !== exp_sum)
        $display("FAIL cksum_value inst%0d: got %h expected %h", i, cksum[i], exp_sum);
      else n_pass++;
    end
    ioctl_bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (cksum[i] !== 16'h0000 || core_reset[i] !== 1'b1)
        $display("FAIL cksum_redownload inst%0d: got cksum=%h core_reset=%0b expected 0000/1", i, cksum[i], core_reset[i]);
      else n_pass++;
    end
    ioctl_bus.ioctl_download = 1'b0;
    tick();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_full_load();
    test_overrun();
    test_short_load();
    test_last_on_fall();
    test_ignored_wr();
    test_region_edges();
    test_reset_mid_load();
    test_full_load();
`ifdef ROM_CKSUM_EN
    test_cksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
